// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I data-memory controller with an embedded word array.
// Handles byte/half/word stores and loads selected by funct3, with sign or
// zero extension on loads. A req/ready handshake with WAIT_STATES extra cycles
// lets the core stall. Misaligned, unsupported or out-of-range accesses get an
// error response.
//
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   req     access request, sampled only while idle
//   we      1 = store, 0 = load
//   funct3  RV32I width/sign code
//   addr    byte address
//   wData   store data, LSB-aligned
//   rData   registered load result (0 for stores and errors)
//   ready   one-cycle response strobe
//   err     access rejected (only meaningful with ready)
//   busy    high whenever an access is in flight
module dmem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wData,
    output logic [31:0]       rData,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned WORD_IDX_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  waitCnt;

    // Access captured at acceptance
    logic              weQ;
    logic [2:0]        funct3Q;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wDataQ;

    // Access currently being decided: live inputs in IDLE, captured copy after
    logic              accWe;
    logic [2:0]        accF3;
    logic [ADDR_W-1:0] accAddr;
    logic [31:0]       accWData;

    logic [WORD_IDX_W-1:0] wordIdx;
    logic [1:0]            lane;
    logic [IDX_W-1:0]      memIdx;

    logic        accErr;
    logic        enterResp;
    logic        commit;
    logic [3:0]  byteEn;
    logic [31:0] storeWord;
    logic [31:0] rawWord;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    logic [31:0] mem [DEPTH_WORDS];

    // Select which access the decode logic looks at
    always_comb begin
        accWe    = weQ;
        accF3    = funct3Q;
        accAddr  = addrQ;
        accWData = wDataQ;
        if (state == IDLE) begin
            accWe    = we;
            accF3    = funct3;
            accAddr  = addr;
            accWData = wData;
        end
    end

    assign wordIdx = accAddr[ADDR_W-1:2];
    assign lane    = accAddr[1:0];
    assign memIdx  = IDX_W'(wordIdx);

    // Error decode: bad code, misalignment, or word beyond the array
    always_comb begin
        logic badF3;
        logic halfMis;
        logic wordMis;
        logic outOfRange;
        badF3      = (accF3 == 3'b011) || (accF3[2:1] == 2'b11) || (accWe && accF3[2]);
        halfMis    = (accF3[1:0] == 2'b01) && lane[0];
        wordMis    = (accF3[1:0] == 2'b10) && (lane != 2'b00);
        outOfRange = 64'(wordIdx) >= 64'(DEPTH_WORDS);
        accErr     = badF3 || halfMis || wordMis || outOfRange;
    end

    // Byte enables and lane-positioned store data
    always_comb begin
        byteEn    = 4'hF;
        storeWord = accWData;
        case (accF3[1:0])
            2'b00: begin
                byteEn    = 4'(4'b0001 << lane);
                storeWord = 32'(accWData << {lane, 3'b000});
            end
            2'b01: begin
                byteEn    = 4'(4'b0011 << {lane[1], 1'b0});
                storeWord = 32'(accWData << {lane[1], 4'b0000});
            end
            default: begin
                byteEn    = 4'hF;
                storeWord = accWData;
            end
        endcase
    end

    // Load extraction and extension (little-endian lanes)
    always_comb begin
        rawWord  = mem[memIdx];
        loadByte = 8'(rawWord >> {lane, 3'b000});
        loadHalf = 16'(rawWord >> {lane[1], 4'b0000});
        case (accF3)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadData = {24'd0, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {16'd0, loadHalf};
            default: loadData = rawWord;
        endcase
    end

    // The edge that moves the FSM into RESP is the one that commits the access
    always_comb begin
        enterResp = 1'b0;
        case (state)
            IDLE:    enterResp = req && ((WAIT_STATES == 0) || accErr);
            BUSY:    enterResp = (waitCnt == LAST_WAIT);
            default: enterResp = 1'b0;
        endcase
    end

    assign commit = enterResp && accWe && !accErr;

    // Array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[memIdx][8*b +: 8] <= storeWord[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= '0;
            weQ     <= 1'b0;
            funct3Q <= '0;
            addrQ   <= '0;
            wDataQ  <= '0;
            rData   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        weQ     <= we;
                        funct3Q <= funct3;
                        addrQ   <= addr;
                        wDataQ  <= wData;
                        busy    <= 1'b1;
                        waitCnt <= '0;
                        if (enterResp) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= accErr;
                            rData <= (accErr || accWe) ? 32'd0 : loadData;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (enterResp) begin
                        state   <= RESP;
                        ready   <= 1'b1;
                        waitCnt <= '0;
                        rData   <= accWe ? 32'd0 : loadData;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: one instance with no wait states and one with
// three. Expected responses go into a scoreboard queue when a request is
// driven and are popped when the DUT raises ready.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, req0, we0, rdy0, err0, busy0;
    logic [2:0]  f30;
    logic [31:0] addr0, wd0, rd0;
    logic        rst3, req3, we3, rdy3, err3, busy3;
    logic [2:0]  f33;
    logic [31:0] addr3, wd3, rd3;

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .req(req0), .we(we0), .funct3(f30),
        .addr(addr0), .wData(wd0), .rData(rd0), .ready(rdy0), .err(err0), .busy(busy0)
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst3), .req(req3), .we(we3), .funct3(f33),
        .addr(addr3), .wData(wd3), .rData(rd3), .ready(rdy3), .err(err3), .busy(busy3)
    );

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nBad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int inst, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (inst == 0) begin
            req0 = r; we0 = w; f30 = f3; addr0 = a; wd0 = d;
        end else begin
            req3 = r; we3 = w; f33 = f3; addr3 = a; wd3 = d;
        end
    endtask

    task automatic sample(input int inst, output logic [31:0] rd, output logic rdy,
                          output logic e, output logic b);
        if (inst == 0) begin
            rd = rd0; rdy = rdy0; e = err0; b = busy0;
        end else begin
            rd = rd3; rdy = rdy3; e = err3; b = busy3;
        end
    endtask

    // One request, then wait (bounded) for the response and check it
    task automatic access(input int inst, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] expRd, input logic expE, input string tag);
        exp_t x;
        int ws, cyc;
        logic got, rdy, e, b;
        logic [31:0] rd;
        ws = (inst == 0) ? 0 : 3;
        @(negedge clk);
        drive(inst, 1'b1, w, f3, a, d);
        x.rd = expRd; x.e = expE; x.lat = expE ? 1 : 1 + ws; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1 drive(inst, 1'b0, w, f3, a, d);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            sample(inst, rd, rdy, e, b);
            if (rdy) got = 1'b1;
            else check({tag, "_busyWait"}, 32'(b), 32'd1);
        end
        x = sb.pop_front();
        check({x.tag, "_ready"}, 32'(got), 32'd1);
        if (got) begin
            check({x.tag, "_latency"}, 32'(cyc), 32'(x.lat));
            check({x.tag, "_rData"}, rd, x.rd);
            check({x.tag, "_err"}, 32'(e), 32'(x.e));
            check({x.tag, "_busyResp"}, 32'(b), 32'd1);
        end
        @(negedge clk);
        sample(inst, rd, rdy, e, b);
        check({x.tag, "_readyOnce"}, 32'(rdy), 32'd0);
        check({x.tag, "_errLow"}, 32'(e), 32'd0);
        check({x.tag, "_idle"}, 32'(b), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic rdy, e, b;

        rst0 = 1'b0; rst3 = 1'b0;
        drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sample(i == 0 ? 0 : 3, rd, rdy, e, b);
            check("reset_rData", rd, 32'd0);
            check("reset_ready", 32'(rdy), 32'd0);
            check("reset_err", 32'(e), 32'd0);
            check("reset_busy", 32'(b), 32'd0);
        end
        rst0 = 1'b1; rst3 = 1'b1;

        // No wait states: word, byte, half accesses
        access(0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, "sw8");
        access(0, 1'b0, 3'b010, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, "lw8");
        access(0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, "sw10");
        access(0, 1'b1, 3'b000, 32'h11, 32'h000000F0, 32'h0, 1'b0, "sb11");
        access(0, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFF0, 1'b0, "lb11");
        access(0, 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000F0, 1'b0, "lbu11");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0000F000, 1'b0, "lw10a");
        access(0, 1'b1, 3'b001, 32'h12, 32'hFFFF8001, 32'h0, 1'b0, "sh12");
        access(0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, "lh12");
        access(0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, "lhu12");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h8001F000, 1'b0, "lw10b");
        access(0, 1'b1, 3'b010, 32'h00, 32'h11223344, 32'h0, 1'b0, "sw0");
        access(0, 1'b1, 3'b001, 32'h03, 32'h0000FFFF, 32'h0, 1'b1, "shMis");
        access(0, 1'b0, 3'b010, 32'h00, 32'h0, 32'h11223344, 1'b0, "lw0a");
        access(0, 1'b0, 3'b000, 32'h03, 32'h0, 32'h00000011, 1'b0, "lb3");
        access(0, 1'b0, 3'b000, 32'h00, 32'h0, 32'h00000044, 1'b0, "lb0");
        access(0, 1'b0, 3'b001, 32'h02, 32'h0, 32'h00001122, 1'b0, "lh2");

        // Error responses
        access(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, "lwOor");
        access(0, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, "f3bad");
        access(0, 1'b1, 3'b010, 32'h02, 32'hFFFFFFFF, 32'h0, 1'b1, "swMis");
        access(0, 1'b1, 3'b100, 32'h00, 32'h0, 32'h0, 1'b1, "sbuBad");
        access(0, 1'b0, 3'b010, 32'h00, 32'h0, 32'h11223344, 1'b0, "lw0b");
        access(0, 1'b1, 3'b010, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, "swLast");
        access(0, 1'b0, 3'b010, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, "lwLast");

        // Continuous req: one response every second cycle
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample(0, rd, rdy, e, b);
            check("cont_ready", 32'(rdy), 32'((i % 2) == 0));
            check("cont_busy", 32'(b), 32'((i % 2) == 0));
            if (rdy) check("cont_rData", rd, 32'hDEADBEEF);
        end
        drive(0, 1'b0, 1'b0, 3'b010, 32'h08, 32'h0);

        // Three wait states
        access(3, 1'b1, 3'b010, 32'h04, 32'hA5A5A5A5, 32'h0, 1'b0, "ws_sw4");
        access(3, 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, "ws_lwMis");
        access(3, 1'b0, 3'b010, 32'h04, 32'h0, 32'hA5A5A5A5, 1'b0, "ws_lw4a");

        // Reset while a store waits in BUSY discards the store
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 3'b010, 32'h04, 32'h12345678);
        @(posedge clk);
        #1 drive(3, 1'b0, 1'b1, 3'b010, 32'h04, 32'h12345678);
        @(negedge clk);
        sample(3, rd, rdy, e, b);
        check("rst_busyBefore", 32'(b), 32'd1);
        check("rst_rDataBefore", rd, 32'hA5A5A5A5);
        @(posedge clk);
        #2 rst3 = 1'b0;
        #1 sample(3, rd, rdy, e, b);
        check("rst_rData", rd, 32'd0);
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_err", 32'(e), 32'd0);
        check("rst_busy", 32'(b), 32'd0);
        @(negedge clk);
        rst3 = 1'b1;
        access(3, 1'b0, 3'b010, 32'h04, 32'h0, 32'hA5A5A5A5, 1'b0, "ws_lw4b");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller, successor to the single-cycle data RAM on the RV32I core's data port. Adds RISC-V byte, half and word stores and loads via funct3, sign/zero extension, and configurable wait states with a req/ready handshake so the core can stall. Adds a misalignment and out-of-range error response. Sits between the core's data port and the data memory array, which it contains.

Parameters:
ADDR_W, 32, byte-address width.
DEPTH_WORDS, 64, number of 32-bit words in the array (power of two not required).
WAIT_STATES, 0, extra cycles spent in BUSY before the response (0..15).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset (asserted when 0).
req  input  1  access request; sampled only in IDLE.
we  input  1  1 = store, 0 = load.
funct3  input  3  RV32I width/sign code.
addr  input  ADDR_W  byte address.
wData  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
rData  output  32  load result, extended to 32 bits.
ready  output  1  one-cycle response strobe.
err  output  1  valid with ready; access rejected.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, ready=0, err=0, rData=0, busy=0, wait counter=0. Array contents are not reset.
- FSM states are IDLE, BUSY and RESP.
- IDLE: when req=1, latch we, funct3, addr and wData, then go to BUSY, or to RESP directly if WAIT_STATES=0 or the access is in error.
- BUSY: count WAIT_STATES cycles, then go to RESP.
- RESP: ready=1 for exactly one cycle; return to IDLE.
- Latency: req accepted at edge N gives ready high during cycle N+1+WAIT_STATES. Requests are accepted only in IDLE, so back-to-back throughput is one access per WAIT_STATES+2 cycles. req outside IDLE is ignored and not queued.
- Word index is addr[ADDR_W-1:2]. Byte lane is addr[1:0]. Little-endian.
- Store funct3 codes:
  - 000 SB: write byte lane addr[1:0].
  - 001 SH: write lanes {addr[1],0}/{addr[1],1}.
  - 010 SW: write all four lanes.
  - Other lanes of the word are untouched.
- Load funct3 codes:
  - 000 LB: sign-extend.
  - 100 LBU: zero-extend.
  - 001 LH: sign-extend.
  - 101 LHU: zero-extend.
  - 010 LW.
- Error conditions, checked at acceptance and all raising err=1 with ready:
  - Unsupported funct3: 011, 110 or 111 for any access; 100 or 101 for a store.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - On error: no array write, rData=0, and WAIT_STATES is skipped (RESP in the next cycle).
- Store commit: the array write happens on the clock edge that enters RESP, never earlier. A store response drives rData=0.
- Load data: read on the edge entering RESP; rData is registered and holds its value until the next response.
- Reset asserted in BUSY: the pending store is discarded and nothing is written. Reset asserted in RESP: the write has already committed.
- err is 0 whenever ready is 0. ready is never high for two consecutive cycles.

Test Plan:
- WAIT_STATES=0: SW addr=0x8 wData=0xDEADBEEF, then LW 0x8 -> ready one cycle after each accept, rData=0xDEADBEEF, err=0.
- SB addr=0x11 wData=0x000000F0 over word 0x10 preset to 0; LB 0x11 -> 0xFFFFFFF0; LBU 0x11 -> 0x000000F0; LW 0x10 -> 0x0000F000.
- SH addr=0x3 -> ready with err=1 and word 0 unchanged. LW addr=DEPTH_WORDS*4 -> err=1, rData=0. funct3=011 -> err=1.
- WAIT_STATES=3: LW accepted at edge N -> busy high cycles N+1..N+4, ready only in cycle N+4. Error access still responds in cycle N+1.
- WAIT_STATES=3: SW 0x4 = 0x12345678, reset pulsed low in BUSY (cycle N+2) -> all outputs 0 immediately; a later LW 0x4 returns the old value.
- Keep req=1 continuously with WAIT_STATES=0 -> ready on every second cycle; no double acceptance; busy toggles accordingly.
